// File: rtl/alu_issue_if.sv
// Bundle between the ID stage, the ALU issue register and the EX consumer.
// The master drives ops and consumes results; the slave is the issue stage.
interface alu_issue_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              alu_src;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [IMM_W-1:0]  imm16;
    logic [4:0]        rd_addr;
    logic              reg_write;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_ctl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        out_rd;
    logic              out_reg_write;
    logic              illegal;
    logic [CNT_W-1:0]  issue_cnt;

    modport master (
        output flush, in_valid, alu_op, funct, alu_src, rs_data, rt_data, imm16,
               rd_addr, reg_write, out_ready,
        input  in_ready, out_valid, alu_ctl, op_a, op_b, out_rd, out_reg_write,
               illegal, issue_cnt
    );

    modport slave (
        input  flush, in_valid, alu_op, funct, alu_src, rs_data, rt_data, imm16,
               rd_addr, reg_write, out_ready,
        output in_ready, out_valid, alu_ctl, op_a, op_b, out_rd, out_reg_write,
               illegal, issue_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the 32-bit MIPS ALU: decodes ALU control, selects and
// extends operand B, and holds the op behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int         DATA_W      = 32,
    parameter int         IMM_W       = 16,
    parameter logic [3:0] ILLEGAL_CTL = 4'd15,
    parameter int         CNT_W       = 16
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);

    typedef struct packed {
        logic       ill;
        logic [3:0] ctl;
    } dec_t;

    function automatic dec_t decode(input logic [1:0] op, input logic [5:0] fn);
        dec_t d;
        d.ill = 1'b0;
        d.ctl = 4'd0;
        case (op)
            2'b00: d.ctl = 4'd2;
            2'b01: d.ctl = 4'd6;
            2'b11: d.ctl = 4'd1;
            default: begin
                case (fn)
                    6'h20:   d.ctl = 4'd2;
                    6'h22:   d.ctl = 4'd6;
                    6'h24:   d.ctl = 4'd0;
                    6'h25:   d.ctl = 4'd1;
                    6'h2A:   d.ctl = 4'd7;
                    6'h27:   d.ctl = 4'd12;
                    default: begin
                        d.ctl = ILLEGAL_CTL;
                        d.ill = 1'b1;
                    end
                endcase
            end
        endcase
        return d;
    endfunction

    // ori zero-extends; every other immediate form sign-extends
    function automatic logic signed [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                            input logic zext);
        logic fill;
        fill = zext ? 1'b0 : imm[IMM_W-1];
        return {{(DATA_W-IMM_W){fill}}, imm};
    endfunction

    dec_t                     dec_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic                     load;
    logic                     fire;

    always_comb begin
        dec_p0 = decode(bus.alu_op, bus.funct);
        b_p0   = bus.rt_data;
        if (bus.alu_src && bus.alu_op != 2'b10)
            b_p0 = extend_imm(bus.imm16, bus.alu_op == 2'b11);
    end

    // ---- p0 (decode) / p1 (issue register) boundary ----
    logic                     vld_p1;
    logic [3:0]               ctl_p1;
    logic signed [DATA_W-1:0] a_p1;
    logic signed [DATA_W-1:0] b_p1;
    logic [4:0]               rd_p1;
    logic                     rw_p1;
    logic                     ill_p1;
    logic [CNT_W-1:0]         cnt_p1;

    assign bus.in_ready = !bus.flush && (!vld_p1 || bus.out_ready);
    assign load         = bus.in_valid && bus.in_ready;
    assign fire         = vld_p1 && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            ctl_p1 <= 4'd0;
            a_p1   <= '0;
            b_p1   <= '0;
            rd_p1  <= 5'd0;
            rw_p1  <= 1'b0;
            ill_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            if (fire)
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            // flush wins; load is already blocked by in_ready during a flush
            if (bus.flush) begin
                vld_p1 <= 1'b0;
            end else if (load) begin
                vld_p1 <= 1'b1;
                ctl_p1 <= dec_p0.ctl;
                a_p1   <= bus.rs_data;
                b_p1   <= b_p0;
                rd_p1  <= bus.rd_addr;
                rw_p1  <= bus.reg_write && !dec_p0.ill;
                ill_p1 <= dec_p0.ill;
            end else if (fire) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = vld_p1;
    assign bus.alu_ctl       = ctl_p1;
    assign bus.op_a          = a_p1;
    assign bus.op_b          = b_p1;
    assign bus.out_rd        = rd_p1;
    assign bus.out_reg_write = rw_p1;
    assign bus.illegal       = ill_p1;
    assign bus.issue_cnt     = cnt_p1;

endmodule
